// File: rtl/ecc_pkg.sv
// Shared types and constants for the ECC bank arbiter.
// The response metadata is sized for up to 256 requesters.
package ecc_pkg;

  localparam int unsigned MaxIdxWidth = 8;

  localparam logic WenRead  = 1'b1;
  localparam logic WenWrite = 1'b0;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef struct packed {
    logic                   valid;
    logic [MaxIdxWidth-1:0] idx;
  } resp_meta_t;

endpackage

// File: rtl/ecc_rr_select.sv
// Round-robin pick among requesters; combinational selection.
// An ungranted pick is held until the bank grants it.
module ecc_rr_select
  import ecc_pkg::*;
#(
  parameter int unsigned NumPorts = 2,
  localparam int unsigned IdxW = idx_width(NumPorts)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NumPorts-1:0] req_i,
  input  logic                gnt_i,
  output logic [IdxW-1:0]     sel_o,
  output logic                vld_o
);

  logic [IdxW-1:0] r_ptr;
  logic [IdxW-1:0] r_held;
  logic            r_hold;
  logic [IdxW-1:0] w_pick;
  int unsigned     w_k;
  logic            w_use_held;

  // Scan from the farthest offset down so the nearest requester wins.
  always_comb begin
    w_pick = r_ptr;
    w_k    = 0;
    for (int i = NumPorts - 1; i >= 0; i--) begin
      w_k = (32'(r_ptr) + 32'(i)) % NumPorts;
      if (req_i[w_k[IdxW-1:0]]) w_pick = w_k[IdxW-1:0];
    end
  end

  assign w_use_held = r_hold & req_i[r_held];
  assign sel_o      = w_use_held ? r_held : w_pick;
  assign vld_o      = |req_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ptr  <= '0;
      r_held <= '0;
      r_hold <= 1'b0;
    end else if (vld_o && gnt_i) begin
      r_ptr  <= (sel_o == IdxW'(NumPorts - 1)) ? '0 : sel_o + 1'b1;
      r_hold <= 1'b0;
    end else if (vld_o) begin
      r_hold <= 1'b1;
      r_held <= sel_o;
    end else begin
      r_hold <= 1'b0;
    end
  end

endmodule

// File: rtl/ecc_bank_arbiter.sv
// Shares one ECC SRAM bank between NumPorts requesters: RR grant, 1-cycle response routing,
// and idle-cycle scrub pacing. Bank gnt low stalls the selected requester without reselecting.
module ecc_bank_arbiter
  import ecc_pkg::*;
#(
  parameter int unsigned NumPorts      = 2,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned BEWidth       = DataWidth / 8,
  parameter int unsigned ScrubCntWidth = 16
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NumPorts-1:0]                 req_i,
  input  logic [NumPorts-1:0][AddrWidth-1:0]  add_i,
  input  logic [NumPorts-1:0]                 wen_i,
  input  logic [NumPorts-1:0][BEWidth-1:0]    be_i,
  input  logic [NumPorts-1:0][DataWidth-1:0]  wdata_i,
  output logic [NumPorts-1:0]                 gnt_o,
  output logic [NumPorts-1:0]                 rvalid_o,
  output logic [NumPorts-1:0][DataWidth-1:0]  rdata_o,
  output logic [NumPorts-1:0]                 single_error_o,
  output logic [NumPorts-1:0]                 multi_error_o,
  output logic                                bank_req_o,
  output logic [AddrWidth-1:0]                bank_add_o,
  output logic                                bank_wen_o,
  output logic [BEWidth-1:0]                  bank_be_o,
  output logic [DataWidth-1:0]                bank_wdata_o,
  input  logic                                bank_gnt_i,
  input  logic [DataWidth-1:0]                bank_rdata_i,
  input  logic                                bank_single_error_i,
  input  logic                                bank_multi_error_i,
  input  logic [ScrubCntWidth-1:0]            scrub_interval_i,
  output logic                                scrub_trigger_o
);

  localparam int unsigned IdxW = idx_width(NumPorts);

  logic [IdxW-1:0]          w_sel;
  logic                     w_any;
  logic                     w_grant;
  logic [IdxW-1:0]          w_ridx;
  logic                     w_unused_idx;
  logic                     w_idle;
  logic                     w_trig;
  resp_meta_t               r_resp;
  logic [ScrubCntWidth-1:0] r_scrub_cnt;

  ecc_rr_select #(
    .NumPorts(NumPorts)
  ) u_rr_select (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .req_i (req_i),
    .gnt_i (bank_gnt_i),
    .sel_o (w_sel),
    .vld_o (w_any)
  );

  assign w_grant      = w_any & bank_gnt_i & ~rst_i;
  assign w_ridx       = r_resp.idx[IdxW-1:0];
  assign w_unused_idx = ^r_resp.idx;

  // Outputs are forced low while reset is asserted, including a pending response.
  always_comb begin
    gnt_o          = '0;
    bank_req_o     = 1'b0;
    bank_add_o     = '0;
    bank_wen_o     = 1'b0;
    bank_be_o      = '0;
    bank_wdata_o   = '0;
    rvalid_o       = '0;
    rdata_o        = '0;
    single_error_o = '0;
    multi_error_o  = '0;
    if (!rst_i && w_any) begin
      bank_req_o    = 1'b1;
      bank_add_o    = add_i[w_sel];
      bank_wen_o    = wen_i[w_sel];
      bank_be_o     = be_i[w_sel];
      bank_wdata_o  = wdata_i[w_sel];
      gnt_o[w_sel]  = bank_gnt_i;
    end
    if (!rst_i && r_resp.valid) begin
      rvalid_o[w_ridx]       = 1'b1;
      rdata_o[w_ridx]        = bank_rdata_i;
      single_error_o[w_ridx] = bank_single_error_i;
      multi_error_o[w_ridx]  = bank_multi_error_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_resp <= '0;
    end else begin
      r_resp.valid <= w_grant;
      r_resp.idx   <= MaxIdxWidth'(w_sel);
    end
  end

  assign w_idle          = ~bank_req_o;
  assign w_trig          = ~rst_i & w_idle & (r_scrub_cnt == '0) & (scrub_interval_i != '0);
  assign scrub_trigger_o = w_trig;

  // A busy cycle at count zero leaves the counter parked so the pulse lands on the next idle cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_scrub_cnt <= scrub_interval_i;
    end else if (scrub_interval_i == '0) begin
      r_scrub_cnt <= '0;
    end else if (w_trig) begin
      r_scrub_cnt <= scrub_interval_i;
    end else if (w_idle && r_scrub_cnt != '0) begin
      r_scrub_cnt <= r_scrub_cnt - 1'b1;
    end
  end

endmodule
